// File: rtl/vstore_serializer_if.sv
// rtl/vstore_serializer_if.sv - data-memory store port between the vector-store unit and memory
interface vstore_serializer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/vstore_serializer.sv
// rtl/vstore_serializer.sv - vector store: snapshots one regfile vector and streams its lanes to memory
module vstore_serializer #(
  parameter int DW    = 32,
  parameter int LANES = 8,
  parameter int AW    = 32,
  parameter int RAW   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          vreg,
  input  logic [AW-1:0]       base_addr,
  input  logic [31:0]         vlen,
  output logic                busy,
  output logic                done,
  output logic [RAW-1:0]      rf_read_addr,
  input  logic [LANES*DW-1:0] rf_vdata,
  vstore_serializer_if.master mem
);

  localparam int IW = $clog2(LANES);
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CAPT,
    S_SEND,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_in;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] base_q;
  logic [DW-1:0] lane_buf [LANES];
  logic          accept;
  logic          last;

  assign cnt_in = (vlen >= 32'(LANES)) ? CW'(LANES) : CW'(vlen);
  assign accept = (state_q == S_SEND) && mem.mem_req && mem.mem_ready;
  assign last   = (CW'(idx_q) == (cnt_q - CW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Empty or illegal-register stores skip the regfile read entirely.
        if (start) begin
          state_d = ((cnt_in == '0) || (vreg == 2'd3)) ? S_DONE : S_ADDR;
        end
      end
      S_ADDR: begin
        busy    = 1'b1;
        state_d = S_CAPT;
      end
      S_CAPT: begin
        busy    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND: begin
        busy = 1'b1;
        if (accept && last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      base_q        <= '0;
      rf_read_addr  <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      for (int i = 0; i < LANES; i++) begin
        lane_buf[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q       <= base_addr;
            cnt_q        <= cnt_in;
            rf_read_addr <= RAW'(vreg);
          end
        end
        S_CAPT: begin
          // Snapshot the whole vector so later regfile writes cannot leak into the stream.
          for (int i = 0; i < LANES; i++) begin
            lane_buf[i] <= rf_vdata[i*DW +: DW];
          end
          idx_q         <= '0;
          mem.mem_req   <= 1'b1;
          mem.mem_addr  <= base_q;
          mem.mem_wdata <= rf_vdata[DW-1:0];
        end
        S_SEND: begin
          if (accept) begin
            if (last) begin
              mem.mem_req <= 1'b0;
            end else begin
              idx_q         <= idx_q + IW'(1);
              mem.mem_addr  <= mem.mem_addr + AW'(4);
              mem.mem_wdata <= lane_buf[idx_q + IW'(1)];
            end
          end
        end
        S_DONE: begin
          rf_read_addr <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
